instr_fetch: RTL and testbench

Instruction fetch stage of the RV64 core. It sits directly upstream of the decode/immediate-generation logic. It owns the PC and issues word-aligned fetch requests to instruction memory over a valid/ready request channel with an in-order response channel. Fetched instructions are buffered in a small FIFO and handed to decode as {pc, instr} with valid/ready; a redirect from execute (branch/jump) flushes everything in flight.

---
 rtl/instr_fetch.sv | 145 ++++++++++++++
 tb/tb_instr_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch : RV64 fetch stage (PC, credit-limited imem requests, output FIFO,
//               redirect flush). Optional IFETCH_PERF_EN adds a retire counter.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_retired_fetch
`endif
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t        state;
    logic [63:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] tag_wr;
    logic [AW-1:0] tag_rd;
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;
    logic [63:0]   tag_mem    [FIFO_DEPTH];
    logic [63:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];

    logic          credit;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          drop_rsp;
    logic [CW-1:0] outstanding_after_rsp;
    logic          unused_redirect_lsb;

    // Slots already promised (buffered + in flight) must leave room for every response.
    assign credit                = (fifo_count + outstanding) < DEPTH_C;
    assign imem_req_valid        = rst_n && (state == FETCH) && credit && !redirect_valid;
    assign imem_req_addr         = pc;
    assign req_fire              = imem_req_valid && imem_req_ready;
    assign out_valid             = (fifo_count != '0);
    assign out_instr             = fifo_instr[fifo_rd];
    assign out_pc                = fifo_pc[fifo_rd];
    assign pop                   = out_valid && out_ready && !redirect_valid;
    assign push                  = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign drop_rsp              = imem_rsp_valid && (drop != '0) && !redirect_valid;
    assign outstanding_after_rsp = outstanding - CW'(imem_rsp_valid);
    assign unused_redirect_lsb   = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fifo_count  <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_mem[i]    <= '0;
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else begin
            outstanding <= outstanding_after_rsp + CW'(req_fire);
            if (req_fire) begin
                tag_mem[tag_wr] <= pc;
                tag_wr          <= tag_wr + 1'b1;
            end
            // Every response retires its tag, whether it is kept or dropped.
            if (imem_rsp_valid) begin
                tag_rd <= tag_rd + 1'b1;
            end

            if (redirect_valid) begin
                pc         <= {redirect_pc[63:2], 2'b00};
                fifo_wr    <= '0;
                fifo_rd    <= '0;
                fifo_count <= '0;
                drop       <= outstanding_after_rsp;
                state      <= (outstanding_after_rsp != '0) ? FLUSH : FETCH;
            end else begin
                if (req_fire) begin
                    pc <= pc + 64'd4;
                end
                if (push) begin
                    fifo_pc[fifo_wr]    <= tag_mem[tag_rd];
                    fifo_instr[fifo_wr] <= imem_rsp_data;
                    fifo_wr             <= fifo_wr + 1'b1;
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + 1'b1;
                end
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if (drop_rsp) begin
                    drop <= drop - 1'b1;
                    if (drop == CW'(1)) begin
                        state <= FETCH;
                    end
                end
            end
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_count <= '0;
        end else if (out_valid && out_ready) begin
            perf_count <= perf_count + 32'd1;
        end
    end

    assign perf_retired_fetch = perf_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// tb_instr_fetch : directed bench with an in-order memory responder and a
// scoreboard of expected {pc, instr} pushed at request acceptance.
module tb_instr_fetch;
    localparam logic [63:0] RPC   = 64'h0000_0000_0000_1000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_retired_fetch;
`endif

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_retired_fetch (perf_retired_fetch)
`endif
    );

    int          total  = 0;
    int          passed = 0;
    int          failed = 0;
    int          cyc    = 0;
    logic [63:0] mq[$];
    logic [95:0] sb[$];
    logic [63:0] popq[$];
    int          fifo_cnt;
    int          drop_m;
    logic [63:0] exp_pc;
    bit          mem_en;
    int          acc_cnt;
    int          first_acc_cyc;
    bit          lat_done;
    logic [63:0] last_acc;
    bit          wrap_seen;
    bit          found;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, check, advance, update model.
    task automatic step();
        bit          acc;
        bit          pop;
        bit          rv;
        logic [95:0] e;
        imem_rsp_valid = mem_en && (mq.size() != 0);
        imem_rsp_data  = 32'h0;
        if (imem_rsp_valid) imem_rsp_data = mem_word(mq[0]);
        #1;
        chk("req_valid", imem_req_valid,
            !redirect_valid && (drop_m == 0) && ((fifo_cnt + mq.size()) < DEPTH));
        chk("out_valid", out_valid, fifo_cnt > 0);
        acc = imem_req_valid && imem_req_ready;
        pop = out_valid && out_ready && !redirect_valid;
        rv  = imem_rsp_valid;
        if (acc) begin
            chk("req_addr", imem_req_addr, exp_pc);
            if (last_acc == 64'hFFFF_FFFF_FFFF_FFFC) begin
                chk("wrap_addr", imem_req_addr, 64'h0);
                wrap_seen = 1'b1;
            end
            last_acc = imem_req_addr;
            acc_cnt++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            sb.push_back({imem_req_addr, mem_word(imem_req_addr)});
        end
        if (out_valid && !lat_done && first_acc_cyc >= 0) begin
            chk("first_latency", cyc - first_acc_cyc, 2);
            lat_done = 1'b1;
        end
        if (pop) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_pc", out_pc, e[95:32]);
                chk("out_instr", out_instr, {32'h0, e[31:0]});
            end
            popq.push_back(out_pc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (redirect_valid) begin
            drop_m   = mq.size() - (rv ? 1 : 0);
            fifo_cnt = 0;
            sb.delete();
            popq.delete();
            exp_pc   = {redirect_pc[63:2], 2'b00};
            last_acc = '1;
        end else begin
            if (rv) begin
                if (drop_m > 0) drop_m--;
                else fifo_cnt++;
            end
            if (pop) fifo_cnt--;
            if (acc) exp_pc = exp_pc + 64'd4;
        end
        if (rv) void'(mq.pop_front());
        if (acc) mq.push_back(last_acc);
        redirect_valid = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        popq.delete();
        fifo_cnt      = 0;
        drop_m        = 0;
        exp_pc        = RPC;
        first_acc_cyc = -1;
        lat_done      = 1'b0;
        last_acc      = '1;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_req_valid"}, imem_req_valid, 0);
        chk({pfx, "_req_addr"}, imem_req_addr, RPC);
        chk({pfx, "_out_valid"}, out_valid, 0);
        chk({pfx, "_out_instr"}, out_instr, 0);
        chk({pfx, "_out_pc"}, out_pc, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b0;
        mem_en         = 1'b0;
        acc_cnt        = 0;
        wrap_seen      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        mem_en         = 1'b1;

        // Streaming from RESET_PC
        repeat (10) step();

        // Decode backpressure
        out_ready = 1'b0;
        acc_cnt   = 0;
        repeat (10) step();
        chk("bp_accepts", acc_cnt <= DEPTH, 1);
        chk("bp_req_valid_low", imem_req_valid, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (8) step();

        // Redirect with two requests outstanding
        mem_en = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (mq.size() == 2) && (fifo_cnt == 0);
        end
        chk("two_outstanding", found, 1);
        redirect_pc    = 64'h2003;
        redirect_valid = 1'b1;
        step();
        mem_en = 1'b1;
        step();
        chk("flush_req_idle", imem_req_valid, 0);
        step();
        chk("flush_done_req", imem_req_valid, 1);
        chk("flush_done_addr", imem_req_addr, 64'h2000);
        repeat (6) step();
        chk("redir_pc0", (popq.size() > 0) ? popq[0] : '1, 64'h2000);
        chk("redir_pc1", (popq.size() > 1) ? popq[1] : '1, 64'h2004);

        // Redirect coinciding with a response and a pop
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (fifo_cnt > 0 && mq.size() > 0) found = 1'b1;
            else step();
        end
        chk("redir_collide_setup", found, 1);
        redirect_pc    = 64'h3000;
        redirect_valid = 1'b1;
        step();
        chk("redir_collide_out_valid", out_valid, 0);
        repeat (8) step();

        // PC wrap at the top of the address space
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        redirect_valid = 1'b1;
        step();
        wrap_seen = 1'b0;
        repeat (12) step();
        chk("wrap_seen", wrap_seen, 1);

        // Asynchronous reset with two requests in flight
        mem_en = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (mq.size() == 2);
        end
        chk("rst_two_outstanding", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        model_reset();
        imem_rsp_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mem_en = 1'b1;
        #1;
        chk("restart_req_valid", imem_req_valid, 1);
        chk("restart_addr", imem_req_addr, RPC);
        repeat (10) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
